// File: rtl/program_loader.sv
// program_loader
//
// Boot-time writer for the 16-bit CPU's instruction memory. A byte stream
// (LEN_HI, LEN_LO, LEN high/low word pairs, XOR checksum) arrives over a
// valid/ready handshake. Each byte pair becomes one 16-bit instruction
// written to consecutive word addresses starting at BASE_ADDR. The CPU PC
// is held until a load finishes with a matching checksum.
//
// Parameters
//   BASE_ADDR  : word address of the first instruction written
//   MAX_WORDS  : instruction memory depth; larger header lengths are errors
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   start      : one-cycle pulse beginning a load (honoured in IDLE/DONE/ERROR)
//   byte_in    : stream byte
//   byte_valid : byte_in is valid
//   byte_ready : loader accepts a byte this cycle (decoded from state)
//   imem_we    : one-cycle write strobe per instruction word
//   imem_addr  : write word address
//   imem_wdata : instruction word {high byte, low byte}
//   cpu_hold   : 1 holds the CPU datapath PC
//   load_done  : last load succeeded
//   load_err   : last load failed
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  // One extra bit so a length of 65535 still compares correctly.
  localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

  // Running checksum update: every byte before the checksum byte is folded in.
  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  xor_q, xor_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
  logic        byte_ready_s;
  logic [15:0] len_s;

  assign len_s = {len_hi_q, byte_in};

  // Ready is a pure decode of the current state.
  always_comb begin
    byte_ready_s = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: byte_ready_s = 1'b1;
      default:                                           byte_ready_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; in the receiving states ready is 1,
  // so byte_valid alone marks a transfer.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    hi_d     = hi_q;
    xor_d    = xor_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    err_d    = err_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          xor_d   = 8'd0;
          idx_d   = 16'd0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (byte_valid) begin
          len_hi_d = byte_in;
          xor_d    = xor_accum(xor_q, byte_in);
          state_d  = S_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (byte_valid) begin
          len_d = len_s;
          xor_d = xor_accum(xor_q, byte_in);
          if ({1'b0, len_s} > MAX_WORDS_C) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else if (len_s == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_HI: begin
        if (byte_valid) begin
          hi_d    = byte_in;
          xor_d   = xor_accum(xor_q, byte_in);
          state_d = S_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_LO: begin
        if (byte_valid) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = {hi_q, byte_in};
          idx_d   = idx_q + 16'd1;
          xor_d   = xor_accum(xor_q, byte_in);
          if ((idx_q + 16'd1) == len_q) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        if (byte_valid) begin
          if (byte_in == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load without issuing a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      hi_q     <= 8'd0;
      xor_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      hi_q     <= hi_d;
      xor_q    <= xor_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  assign byte_ready = byte_ready_s;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: expected writes are queued as low data bytes
// are presented and popped by a monitor whenever imem_we is seen.
module tb_program_loader;

  localparam logic [15:0] BASE = 16'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  stream_q[$];
  logic [31:0] exp_w;
  logic        lo_flag = 1'b0;
  logic        we_due = 1'b0;
  logic        mon_en = 1'b0;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // A write is due exactly one cycle after a low data byte transfers.
  always @(posedge clk) we_due <= !reset && byte_valid && byte_ready && lo_flag;

  // Scoreboard monitor: write timing and content.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (imem_we !== we_due) begin
        errors++;
        $display("FAIL we_timing: imem_we=%b expected=%b at %0t", imem_we, we_due, $time);
      end
      if (imem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, none expected", imem_addr, imem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({imem_addr, imem_wdata} !== exp_w) begin
            errors++;
            $display("FAIL write_data: got addr=%h data=%h expected addr=%h data=%h",
                     imem_addr, imem_wdata, exp_w[31:16], exp_w[15:0]);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic make_two_word(input logic [7:0] cks);
    stream_q = '{8'h00, 8'h02, 8'h41, 8'h23, 8'h80, 8'h05, cks};
  endtask

  task automatic make_random(input int n);
    logic [15:0] ln;
    logic [7:0]  x;
    logic [7:0]  b;
    ln = 16'(n);
    stream_q = '{ln[15:8], ln[7:0]};
    x = ln[15:8] ^ ln[7:0];
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      stream_q.push_back(b);
      x = x ^ b;
    end
    stream_q.push_back(x);
  endtask

  // Present one byte after 'gap' idle cycles and wait (bounded) for it to transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic lo);
    int n;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = b;
    byte_valid = 1'b1;
    lo_flag = lo;
    n = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: byte_ready=%b expected=1", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    lo_flag = 1'b0;
  endtask

  // Send stream_q[from..to-1]; expected writes are pushed as low bytes go out.
  task automatic send_stream(input int from, input int to, input int max_gap);
    int nw;
    logic lo;
    nw = {stream_q[0], stream_q[1]};
    if (nw > 256) nw = 0;
    for (int i = from; i < to; i++) begin
      lo = (i >= 2) && (i < 2 + 2 * nw) && (i % 2 == 1);
      if (lo) exp_q.push_back({BASE + 16'((i - 3) / 2), stream_q[i - 1], stream_q[i]});
      send_byte(stream_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, lo);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (load_done !== 1'b1 && load_err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (load_done !== 1'b1 && load_err !== 1'b1) begin
      errors++;
      $display("FAIL end_timeout: done=%b err=%b expected one of them 1", load_done, load_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err} !==
        {1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b expected 0 0 0000 0000 1 0 0",
               byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_two_word();
    pulse_start();
    make_two_word(8'hE5);
    send_stream(0, 7, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL two_word_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL two_word_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    make_two_word(8'hE4);
    send_stream(0, 7, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      errors++;
      $display("FAIL bad_cks_status: done/err/hold=%b%b%b expected 011", load_done, load_err, cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_cks_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_zero_length();
    pulse_start();
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0, 3, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL zero_len_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_oversize();
    pulse_start();
    stream_q = '{8'h01, 8'h01};
    send_stream(0, 2, 0);
    @(negedge clk);
    checks++;
    if ({byte_ready, load_done, load_err, cpu_hold} !== 4'b0011) begin
      errors++;
      $display("FAIL oversize_status: rdy/done/err/hold=%b%b%b%b expected 0011",
               byte_ready, load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_back_to_back();
    // Largest legal length, no gaps: a write every second cycle.
    pulse_start();
    make_random(256);
    send_stream(0, stream_q.size(), 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL max_len_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_len_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stalled();
    pulse_start();
    make_two_word(8'hE5);
    send_stream(0, 7, 5);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL stalled_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stalled_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    make_two_word(8'hE5);
    send_stream(0, 4, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err} !==
        {1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_values: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b expected 0 0 0000 0000 1 0 0",
               byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_start();
    send_stream(0, 7, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL reload_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_start_during_load();
    pulse_start();
    make_two_word(8'hE5);
    send_stream(0, 4, 0);
    pulse_start();
    @(negedge clk);
    checks++;
    if ({byte_ready, cpu_hold, load_done, load_err} !== 4'b1100) begin
      errors++;
      $display("FAIL start_ignored: rdy/hold/done/err=%b%b%b%b expected 1100",
               byte_ready, cpu_hold, load_done, load_err);
    end
    @(posedge clk); #1;
    send_stream(4, 7, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_mid_status: done/err/hold=%b%b%b pending=%0d expected 100 pending=0",
               load_done, load_err, cpu_hold, exp_q.size());
      exp_q.delete();
    end
    // start from DONE begins a fresh load
    pulse_start();
    @(negedge clk);
    checks++;
    if ({byte_ready, cpu_hold, load_done, load_err} !== 4'b1100) begin
      errors++;
      $display("FAIL start_in_done: rdy/hold/done/err=%b%b%b%b expected 1100",
               byte_ready, cpu_hold, load_done, load_err);
    end
    @(posedge clk); #1;
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0, 3, 0);
    wait_end();
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL restart_status: done/err/hold=%b%b%b expected 100", load_done, load_err, cpu_hold);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_zero_length();
    test_oversize();
    test_back_to_back();
    test_stalled();
    test_reset_mid_load();
    test_start_during_load();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
